mantissa_subtractor: RTL and testbench

MANTISSA_SUBTRACTOR -- requirements
Module: mantissa_subtractor

---
 rtl/fp_alu_pkg.sv | 15 +
 rtl/cla_sub_slice.sv | 41 ++++
 rtl/mantissa_subtractor.sv | 128 ++++++++++++
 tb/tb_mantissa_subtractor.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/fp_alu_pkg.sv
// rtl/fp_alu_pkg.sv - shared FSM state type and default widths for the FP ALU datapath
package fp_alu_pkg;

    localparam int DEF_WIDTH = 24;
    localparam int DEF_SLICE = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SUB,
        ST_NEG,
        ST_NORM,
        ST_DONE
    } state_t;

endpackage

// File: rtl/cla_sub_slice.sv
// rtl/cla_sub_slice.sv - SLICE-bit borrow-lookahead subtractor, d = x - y - bin
module cla_sub_slice #(
    parameter int SLICE = 4
) (
    input  logic [SLICE-1:0] x,
    input  logic [SLICE-1:0] y,
    input  logic             bin,
    output logic [SLICE-1:0] d,
    output logic             bout
);

    logic [SLICE-1:0] w_g;
    logic [SLICE-1:0] w_p;
    logic [SLICE:0]   w_b;

    // A bit generates a borrow when x=0,y=1 and passes one through when x==y.
    assign w_g = ~x & y;
    assign w_p = ~(x ^ y);

    // Each borrow is a flat sum of products of g/p/bin, independent of lower borrows.
    always_comb begin
        logic v_t;
        v_t    = 1'b0;
        w_b    = '0;
        w_b[0] = bin;
        for (int i = 0; i < SLICE; i++) begin
            v_t = bin;
            for (int k = 0; k <= i; k++) v_t = v_t & w_p[k];
            w_b[i+1] = v_t;
            for (int j = 0; j <= i; j++) begin
                v_t = w_g[j];
                for (int k = j + 1; k <= i; k++) v_t = v_t & w_p[k];
                w_b[i+1] = w_b[i+1] | v_t;
            end
        end
    end

    assign d    = x ^ y ^ w_b[SLICE-1:0];
    assign bout = w_b[SLICE];

endmodule

// File: rtl/mantissa_subtractor.sv
// rtl/mantissa_subtractor.sv - slice-serial |a-b| with normalization and lead-zero count
module mantissa_subtractor
    import fp_alu_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SLICE = DEF_SLICE
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           a_in,
    input  logic [WIDTH-1:0]           b_in,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           diff_out,
    output logic [$clog2(WIDTH+1)-1:0] lz_count,
    output logic                       swap,
    output logic                       zero
);

    localparam int NSL = WIDTH / SLICE;
    localparam int CW  = $clog2(NSL + 1);
    localparam int LZW = $clog2(WIDTH + 1);

    state_t           r_state, w_next;
    logic [WIDTH-1:0] r_a, r_b, r_diff;
    logic             r_borrow;
    logic [CW-1:0]    r_cnt;
    logic [LZW-1:0]   r_lz;
    logic             r_swap, r_zero;

    logic             w_neg, w_last, w_bout;
    logic [SLICE-1:0] w_x, w_y, w_d;
    logic [WIDTH-1:0] w_diff_next;

    // NEG reuses the slice as 0 - diff, so only the operand muxes change.
    assign w_neg  = (r_state == ST_NEG);
    assign w_last = (r_cnt == CW'(NSL - 1));
    assign w_x    = w_neg ? '0 : r_a[int'(r_cnt)*SLICE +: SLICE];
    assign w_y    = w_neg ? r_diff[int'(r_cnt)*SLICE +: SLICE] : r_b[int'(r_cnt)*SLICE +: SLICE];

    cla_sub_slice #(.SLICE(SLICE)) u_slice (
        .x    (w_x),
        .y    (w_y),
        .bin  (r_borrow),
        .d    (w_d),
        .bout (w_bout)
    );

    always_comb begin
        w_diff_next = r_diff;
        w_diff_next[int'(r_cnt)*SLICE +: SLICE] = w_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (in_valid) w_next = ST_SUB;
            ST_SUB: if (w_last) begin
                if (w_bout)                  w_next = ST_NEG;
                else if (w_diff_next == '0)  w_next = ST_DONE;
                else if (w_diff_next[WIDTH-1]) w_next = ST_DONE;
                else                         w_next = ST_NORM;
            end
            ST_NEG: if (w_last) w_next = w_diff_next[WIDTH-1] ? ST_DONE : ST_NORM;
            ST_NORM: if (r_diff[WIDTH-2]) w_next = ST_DONE;
            ST_DONE: if (out_ready) w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_diff   <= '0;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
            r_lz     <= '0;
            r_swap   <= 1'b0;
            r_zero   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: if (in_valid) begin
                    r_a      <= a_in;
                    r_b      <= b_in;
                    r_diff   <= '0;
                    r_borrow <= 1'b0;
                    r_cnt    <= '0;
                    r_lz     <= '0;
                    r_swap   <= 1'b0;
                    r_zero   <= 1'b0;
                end
                ST_SUB, ST_NEG: begin
                    r_diff <= w_diff_next;
                    if (w_last) begin
                        r_cnt    <= '0;
                        r_borrow <= 1'b0;
                        if (!w_neg && w_bout) r_swap <= 1'b1;
                        if (!w_neg && !w_bout && (w_diff_next == '0)) r_zero <= 1'b1;
                    end else begin
                        r_cnt    <= r_cnt + 1'b1;
                        r_borrow <= w_bout;
                    end
                end
                ST_NORM: begin
                    r_diff <= r_diff << 1;
                    r_lz   <= r_lz + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = rst_n && (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign diff_out  = r_diff;
    assign lz_count  = r_lz;
    assign swap      = r_swap;
    assign zero      = r_zero;

endmodule

// File: tb/tb_mantissa_subtractor.sv
// tb/tb_mantissa_subtractor.sv - self-checking bench for mantissa_subtractor
module tb_mantissa_subtractor;

    localparam int W = 24;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  a_in = '0;
    logic [W-1:0]  b_in = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  diff_out;
    logic [4:0]    lz_count;
    logic          swap;
    logic          zero;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mantissa_subtractor dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_in      (a_in),
        .b_in      (b_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff_out  (diff_out),
        .lz_count  (lz_count),
        .swap      (swap),
        .zero      (zero)
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] diff;
        logic [4:0]   lz;
        logic         sw;
        logic         zr;
        int           lat;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: magnitude by plain arithmetic, then shift until the top bit is set.
    task automatic ref_model(input logic [W-1:0] a, input logic [W-1:0] b,
                             output logic [W-1:0] d, output logic [4:0] lz,
                             output logic sw, output logic zr, output int lat);
        int unsigned mag;
        int n;
        sw  = (a < b);
        zr  = (a == b);
        mag = sw ? (int'(b) - int'(a)) : (int'(a) - int'(b));
        n   = 0;
        if (mag != 0) while (mag < (1 << (W - 1))) begin
            mag = mag * 2;
            n++;
        end
        d   = mag[W-1:0];
        lz  = 5'(n);
        lat = 1 + W / 4 + (sw ? W / 4 : 0) + n;
    endtask

    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
        for (int i = 0; i < 50 && !in_ready; i++) begin
            @(posedge clk); #1;
        end
        chk("in_ready_before_accept", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        a_in = a;
        b_in = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a_in = W'($urandom);
        b_in = W'($urandom);
    endtask

    task automatic wait_done(output int lat);
        lat = 1;
        while (!out_valid && lat < 300) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) chk("timeout_out_valid", 32'(out_valid), 32'd1);
    endtask

    task automatic finish_op();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic run_and_check(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [W-1:0] ed, input logic [4:0] el,
                                 input logic es, input logic ez, input int elat);
        int lat;
        start_op(a, b);
        wait_done(lat);
        chk({tag, "_diff"}, 32'(diff_out), 32'(ed));
        chk({tag, "_lz"},   32'(lz_count), 32'(el));
        chk({tag, "_swap"}, 32'(swap),     32'(es));
        chk({tag, "_zero"}, 32'(zero),     32'(ez));
        chk({tag, "_lat"},  32'(lat),      32'(elat));
        finish_op();
    endtask

    initial begin
        logic [W-1:0] ra, rb, ed;
        logic [4:0]   el;
        logic         es, ez;
        int           elat;

        vecs[0] = '{a: 24'hC00000, b: 24'h400000, diff: 24'h800000, lz: 5'd0,  sw: 1'b0, zr: 1'b0, lat: 7};
        vecs[1] = '{a: 24'h400000, b: 24'hC00000, diff: 24'h800000, lz: 5'd0,  sw: 1'b1, zr: 1'b0, lat: 13};
        vecs[2] = '{a: 24'h800001, b: 24'h800000, diff: 24'h800000, lz: 5'd23, sw: 1'b0, zr: 1'b0, lat: 30};
        vecs[3] = '{a: 24'hABCDEF, b: 24'hABCDEF, diff: 24'h000000, lz: 5'd0,  sw: 1'b0, zr: 1'b1, lat: 7};
        vecs[4] = '{a: 24'hFFFFFF, b: 24'h000000, diff: 24'hFFFFFF, lz: 5'd0,  sw: 1'b0, zr: 1'b0, lat: 7};
        vecs[5] = '{a: 24'h000000, b: 24'h000001, diff: 24'h800000, lz: 5'd23, sw: 1'b1, zr: 1'b0, lat: 36};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready",  32'(in_ready),  32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_diff",      32'(diff_out),  32'd0);
        chk("rst_lz",        32'(lz_count),  32'd0);
        chk("rst_swap",      32'(swap),      32'd0);
        chk("rst_zero",      32'(zero),      32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        for (int i = 0; i < 6; i++)
            run_and_check($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].diff,
                          vecs[i].lz, vecs[i].sw, vecs[i].zr, vecs[i].lat);

        for (int i = 0; i < 40; i++) begin
            ra = W'($urandom) >> $urandom_range(0, W - 1);
            rb = (i % 5 == 0) ? ra : (W'($urandom) >> $urandom_range(0, W - 1));
            ref_model(ra, rb, ed, el, es, ez, elat);
            run_and_check($sformatf("rnd%0d", i), ra, rb, ed, el, es, ez, elat);
        end

        // Backpressure: DONE held with ignored in_valid pulses, then no same-cycle accept.
        start_op(24'hC00000, 24'h400000);
        wait_done(elat);
        for (int i = 0; i < 5; i++) begin
            in_valid = i[0];
            a_in = W'($urandom);
            b_in = W'($urandom);
            @(posedge clk); #1;
            chk("hold_out_valid", 32'(out_valid), 32'd1);
            chk("hold_diff",      32'(diff_out),  32'h800000);
            chk("hold_lz",        32'(lz_count),  32'd0);
            chk("hold_in_ready",  32'(in_ready),  32'd0);
        end
        in_valid = 1'b1;
        a_in = 24'h000001;
        b_in = 24'h000000;
        finish_op();
        in_valid = 1'b0;
        chk("handshake_idle_in_ready", 32'(in_ready),  32'd1);
        chk("handshake_out_valid",     32'(out_valid), 32'd0);

        // Asynchronous reset in the middle of SUB.
        start_op(24'h800001, 24'h800000);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_in_ready",  32'(in_ready),  32'd0);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_diff",      32'(diff_out),  32'd0);
        chk("midrst_lz",        32'(lz_count),  32'd0);
        chk("midrst_swap",      32'(swap),      32'd0);
        chk("midrst_zero",      32'(zero),      32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("midrst_no_out_valid", 32'(out_valid), 32'd0);
        end
        run_and_check("after_rst", 24'hC00000, 24'h400000, 24'h800000, 5'd0, 1'b0, 1'b0, 7);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
